// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter feeding a shared register-file read mux through a 2-stage pipeline.
// Optional sticky lock of the most recent winner is enabled by defining RF_ARB_LOCK_EN.
module rf_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic               hold,
`ifdef RF_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]      mux_sel,
    input  logic [DW-1:0]      mux_data,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy
);

    // Handshake: requester i transfers in any cycle where req_valid[i] && req_ready[i];
    // req_ready is one-hot or zero and never depends on anything later in the pipeline.

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic            lock_hit;
    logic            s1_valid_q;
    logic [PW-1:0]   s1_idx_q;
    logic [AW-1:0]   mux_sel_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;

`ifdef RF_ARB_LOCK_EN
    logic [PW-1:0]   last_win_q;
    logic            have_win_q;
`endif

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        lock_hit  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!win_found && req_valid[PW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
`ifdef RF_ARB_LOCK_EN
        // A locked previous winner that is still requesting overrides the rotation.
        if (have_win_q && req_lock[last_win_q] && req_valid[last_win_q]) begin
            win_found = 1'b1;
            win_idx   = last_win_q;
            lock_hit  = 1'b1;
        end
`endif
        if (hold) begin
            win_found = 1'b0;
        end
        req_ready = win_found ? (NREQ'(1) << win_idx) : '0;
        rr_ptr_d  = rr_ptr_q;
        if (win_found && !lock_hit) begin
            rr_ptr_d = PW'((int'(win_idx) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            mux_sel_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= win_found;
            if (win_found) begin
                s1_idx_q  <= win_idx;
                mux_sel_q <= req_addr[int'(win_idx)*AW +: AW];
            end
            rsp_valid_q <= s1_valid_q ? (NREQ'(1) << s1_idx_q) : '0;
            if (s1_valid_q) begin
                rsp_data_q <= mux_data;
            end
        end
    end

`ifdef RF_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_win_q <= '0;
            have_win_q <= 1'b0;
        end else if (win_found) begin
            last_win_q <= win_idx;
            have_win_q <= 1'b1;
        end
    end
`endif

    assign mux_sel   = mux_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Randomized + directed bench for rf_read_arbiter with a queue-based scoreboard.
// Define RF_ARB_LOCK_EN for both files to exercise the lock variant.
module tb_rf_read_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int EW   = 32 + NREQ + DW;
    localparam int SW   = 32 + AW;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic               hold = 1'b0;
    logic [NREQ-1:0]    req_lock = '0;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      mux_sel;
    logic [DW-1:0]      mux_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               busy;

    rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .hold(hold),
`ifdef RF_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready),
        .mux_sel(mux_sel),
        .mux_data(mux_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file behind the 32:1 mux.
    logic [DW-1:0] rf [32];
    assign mux_data = rf[mux_sel];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [EW-1:0] exp_q[$];
    logic [SW-1:0] sel_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: round-robin pointer and lock holder as plain integers.
    int m_ptr = 0;
    int m_last = 0;
    bit m_have = 0;
    bit h1 = 0, h2 = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_ptr = 0; m_have = 0; h1 = 0; h2 = 0;
            exp_q.delete();
            sel_q.delete();
            check("reset_rsp_valid", rsp_valid, 0);
            check("reset_mux_sel", mux_sel, 0);
            check("reset_rsp_data", rsp_data, 0);
            check("reset_busy", busy, 0);
        end else begin
            int w;
            bit lk;
            logic [AW-1:0] a;
            w = -1;
            lk = 0;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
`ifdef RF_ARB_LOCK_EN
            if (m_have && req_lock[m_last] && req_valid[m_last]) begin
                w = m_last;
                lk = 1;
            end
`endif
            if (hold) w = -1;
            check("req_ready", req_ready, (w < 0) ? 0 : (64'd1 << w));
            check("busy", busy, h1 | h2);
            h2 = h1;
            h1 = (w >= 0);
            if (w >= 0) begin
                a = req_addr[w*AW +: AW];
                exp_q.push_back({32'(cyc + 2), NREQ'(1 << w), rf[a]});
                sel_q.push_back({32'(cyc + 1), a});
                if (!lk) m_ptr = (w + 1) % NREQ;
                m_last = w;
                m_have = 1;
            end
        end
    end

    // Monitor: pops expectations as the DUT presents responses and mux selects.
    logic [AW-1:0] last_sel = '0;
    logic [DW-1:0] last_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            last_sel = '0;
            last_data = '0;
        end else begin
            logic [EW-1:0] e;
            logic [SW-1:0] s;
            if (rsp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e[EW-1 -: 32]);
                    check("rsp_valid", rsp_valid, e[DW+NREQ-1 -: NREQ]);
                    check("rsp_data", rsp_data, e[DW-1:0]);
                    last_data = e[DW-1:0];
                end
            end else begin
                check("rsp_data_hold", rsp_data, last_data);
                if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
                    e = exp_q.pop_front();
                    check("rsp_missing", rsp_valid, e[DW+NREQ-1 -: NREQ]);
                end
            end
            if (sel_q.size() > 0 && int'(sel_q[0][SW-1 -: 32]) == cyc) begin
                s = sel_q.pop_front();
                check("mux_sel", mux_sel, s[AW-1:0]);
                last_sel = s[AW-1:0];
            end else begin
                check("mux_sel_hold", mux_sel, last_sel);
            end
        end
    end

    // Driver.
    task automatic tick(output logic [NREQ-1:0] rdy);
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [NREQ-1:0] r;
        req_valid = '0; hold = 1'b0; req_lock = '0;
        for (int i = 0; i < n; i++) tick(r);
    endtask

    task automatic do_reset();
        logic [NREQ-1:0] r;
        req_valid = '0; hold = 1'b0; req_lock = '0;
        reset = 1'b1;
        tick(r);
        reset = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        int ord033[5] = '{0, 1, 2, 3, 0};
        int ord036[3] = '{3, 0, 3};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[7] = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single read granted on the first edge after reset.
        req_valid = 4'b0001;
        req_addr = (NREQ*AW)'($urandom);
        req_addr[0 +: AW] = 5'd7;
        tick(r);
        check("single_grant", r, 4'b0001);
        idle(4);

        // All requesting from reset.
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            req_addr = (NREQ*AW)'($urandom);
            tick(r);
            check("rr_order", r, 4'b0001 << ord033[i]);
        end
        idle(4);

        // Hold one cycle after a grant.
        req_valid = 4'b0001;
        tick(r);
        req_valid = 4'b1111;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(r);
            check("hold_ready", r, 0);
        end
        idle(3);

        // Reset in cycle N+1 of a grant.
        do_reset();
        req_valid = 4'b0001;
        req_addr = (NREQ*AW)'($urandom);
        tick(r);
        req_valid = '0;
        reset = 1'b1;
        tick(r);
        reset = 1'b0;
        idle(3);
        req_valid = 4'b1111;
        tick(r);
        check("ptr_after_reset", r, 4'b0001);
        idle(3);

        // Wrap-around with pointer at 3.
        do_reset();
        req_valid = 4'b0100;
        tick(r);
        req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            req_addr = (NREQ*AW)'($urandom);
            tick(r);
            check("wrap_order", r, 4'b0001 << ord036[i]);
        end
        idle(3);

`ifdef RF_ARB_LOCK_EN
        do_reset();
        req_valid = 4'b0011;
        req_lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick(r);
            check("lock_grant", r, 4'b0001);
        end
        req_lock = '0;
        tick(r);
        check("lock_release", r, 4'b0010);
        idle(3);
`endif

        // Random traffic with occasional hold, lock and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                tick(r);
                reset = 1'b0;
            end
            req_valid = NREQ'($urandom);
            req_addr = (NREQ*AW)'($urandom);
            hold = ($urandom_range(0, 9) == 0);
            req_lock = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            tick(r);
        end
        idle(4);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the 32:1 read mux.
REQ-002 SHALL have parameter AW, default 5: select width, which equals the mux S width.
REQ-003 SHALL have parameter DW, default 32: data width, which equals the mux Y width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ bits: per-requester read request.
REQ-007 SHALL have port req_addr, input, NREQ*AW bits: register index, with requester i in bits [i*AW +: AW].
REQ-008 SHALL have port hold, input, 1 bit: suppresses new grants while high.
REQ-009 SHALL have port req_ready, output, NREQ bits: one-hot grant (combinational).
REQ-010 SHALL have port mux_sel, output, AW bits: registered drive to the mux S input.
REQ-011 SHALL have port mux_data, input, DW bits: mux Y output.
REQ-012 SHALL have port rsp_valid, output, NREQ bits: one-hot response strobe (registered).
REQ-013 SHALL have port rsp_data, output, DW bits: registered read data.
REQ-014 SHALL have port busy, output, 1 bit: high while any grant is in flight.

Function
REQ-015 SHALL complete a handshake for requester i in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 SHALL assert at most one req_ready bit per cycle; req_ready SHALL be all-zero when hold=1 or req_valid=0.
REQ-017 SHALL arbitrate round-robin: search starts at pointer rr_ptr, ascending and wrapping NREQ-1 -> 0; the first valid requester wins.
REQ-018 SHALL load rr_ptr with (winner+1) mod NREQ on each handshake; rr_ptr SHALL hold when there is no handshake.
REQ-019 SHALL form a 2-stage pipeline, with handshake in cycle N:
  - cycle N+1: mux_sel = winner's req_addr.
  - edge ending N+1: rsp_data <= mux_data.
  - cycle N+2: rsp_valid[winner] = 1 for exactly one cycle.
REQ-020 SHALL sustain one handshake per cycle, so back-to-back grants produce back-to-back responses.
REQ-021 SHALL hold mux_sel at its last value when there is no handshake; rsp_data SHALL also hold.
REQ-022 SHALL let responses already in flight complete when hold rises; only new grants are blocked.
REQ-023 SHALL drive busy = (stage-1 valid) OR (stage-2 valid).
REQ-024 SHALL treat req_addr of a non-winning requester as don't-care.
REQ-025 SHALL give a requester that drops req_valid before its grant no grant and no response.

Reset
REQ-026 SHALL, while reset=1, asynchronously force all of the following to 0, regardless of clk:
  - rr_ptr, mux_sel, rsp_data, rsp_valid, busy;
  - all pipeline valid bits.
REQ-027 SHALL discard in-flight requests on reset mid-operation: no rsp_valid after reset deasserts.
REQ-028 SHALL allow a grant on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL add input port req_lock (NREQ bits) when RF_ARB_LOCK_EN is defined.
REQ-030 SHALL, with RF_ARB_LOCK_EN defined, behave as follows when the most recent winner w has req_lock[w]=1 and req_valid[w]=1:
  - w wins again regardless of rr_ptr;
  - rr_ptr does not advance on that locked grant.
REQ-031 SHALL, without RF_ARB_LOCK_EN, omit the req_lock port and use pure round-robin as in REQ-017.

Verification
REQ-032 SHALL cover a single read: req_valid=0001, addr0=7, mux_data=0xDEADBEEF -> mux_sel=7 at N+1; rsp_valid=0001 and rsp_data=0xDEADBEEF at N+2.
REQ-033 SHALL cover all requesting: req_valid=1111 held 5 cycles, starting from reset -> grant order 0,1,2,3,0; rsp_valid pulses one per cycle in the same order.
REQ-034 SHALL cover hold: hold=1 one cycle after a grant -> that grant's response still arrives; req_ready=0000 while hold=1; busy falls 2 cycles after the last grant.
REQ-035 SHALL cover reset mid-operation: reset pulsed in cycle N+1 of a grant -> rsp_valid stays 0; rr_ptr=0; mux_sel=0.
REQ-036 SHALL cover wrap-around: rr_ptr=3 with req_valid=1001 -> requester 3 granted, then requester 0, then requester 3.
REQ-037 SHALL cover lock (RF_ARB_LOCK_EN only): req_valid=0011, req_lock[0]=1 for 3 cycles -> requester 0 granted 3 times, then requester 1 once lock drops.
